// File: rtl/wide_mult_pkg.sv
// Shared widths, FSM encoding and the reference expected-value formula
// for the wide_mult_top result checker.
package wide_mult_pkg;

    localparam int A_W     = 128;
    localparam int B_W     = 64;
    localparam int C_W     = 64;
    localparam int D_W     = 128;
    localparam int E_W     = 128;
    localparam int RES_W   = 256;
    localparam int S_W     = C_W + E_W;
    localparam int EXP_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // exp = sext(A) + zext({B,64'h0}) + C*(sext(D) + ((C*E) >>> 1)), 256-bit wrap
    function automatic logic [RES_W-1:0] exp_value(
        input logic [A_W-1:0] a,
        input logic [B_W-1:0] b,
        input logic [C_W-1:0] c,
        input logic [D_W-1:0] d,
        input logic [E_W-1:0] e
    );
        logic [S_W-1:0]   p1;
        logic [S_W-1:0]   h;
        logic [S_W-1:0]   s;
        logic [RES_W-1:0] p2;
        p1 = {{E_W{c[C_W-1]}}, c} * {{C_W{e[E_W-1]}}, e};
        h  = $signed(p1) >>> 1;
        s  = {{(S_W-D_W){d[D_W-1]}}, d} + h;
        p2 = {{(RES_W-C_W){c[C_W-1]}}, c} * {{(RES_W-S_W){s[S_W-1]}}, s};
        return {{(RES_W-A_W){a[A_W-1]}}, a}
             + {{(RES_W-B_W-64){1'b0}}, b, 64'h0}
             + p2;
    endfunction

endpackage

// File: rtl/wide_mult_exp_fifo.sv
// Synchronous expectation FIFO; a pop on a full queue frees room for a
// same-cycle push, a pop on an empty queue is ignored.
module wide_mult_exp_fifo
    import wide_mult_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/wide_mult_checker.sv
// On-chip scoreboard for wide_mult_top: recomputes each expectation in a
// 4-stage pipeline, queues it and compares against the returned results.
module wide_mult_checker
    import wide_mult_pkg::*;
#(
    parameter int NUM_VECTORS = 47,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [A_W-1:0]   A,
    input  logic [B_W-1:0]   B,
    input  logic [C_W-1:0]   C,
    input  logic [D_W-1:0]   D,
    input  logic [E_W-1:0]   E,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      checked_count,
    output logic [15:0]      mismatch_count,
    output logic [15:0]      first_bad_idx,
    output logic             err_underflow,
    output logic             err_overflow,
    output logic             err_timeout
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_e           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [15:0]      r_chk;
    logic [15:0]      r_mis;
    logic [15:0]      r_fbi;
    logic             r_uf;
    logic             r_of;
    logic             r_to_err;
    logic [TO_W-1:0]  r_to;
    logic [EXP_LAT-1:0] r_v;

    logic [S_W-1:0]   r1_p1;
    logic [A_W-1:0]   r1_a;
    logic [B_W-1:0]   r1_b;
    logic [C_W-1:0]   r1_c;
    logic [D_W-1:0]   r1_d;
    logic [S_W-1:0]   r2_s;
    logic [A_W-1:0]   r2_a;
    logic [B_W-1:0]   r2_b;
    logic [C_W-1:0]   r2_c;
    logic [RES_W-1:0] r3_p2;
    logic [A_W-1:0]   r3_a;
    logic [B_W-1:0]   r3_b;
    logic [RES_W-1:0] r4_exp;

    logic [S_W-1:0]   w_p1;
    logic [S_W-1:0]   w_h;
    logic [S_W-1:0]   w_s;
    logic [RES_W-1:0] w_p2;
    logic [RES_W-1:0] w_exp;
    logic [RES_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;

    logic             w_run;
    logic             w_pop_req;
    logic             w_push_req;
    logic             w_pop;
    logic             w_uf;
    logic             w_of;
    logic             w_mis;
    logic             w_active;
    logic             w_to_hit;
    logic             w_any_err;
    logic             w_finish;
    logic [15:0]      w_chk_nxt;
    logic [15:0]      w_mis_nxt;
    logic [15:0]      w_fbi_nxt;
    logic [TO_W-1:0]  w_to_nxt;

    // Sign handling is done by explicit extension; only the halving needs
    // a signed view so the shift floors toward minus infinity.
    assign w_p1  = {{E_W{C[C_W-1]}}, C} * {{C_W{E[E_W-1]}}, E};
    assign w_h   = $signed(r1_p1) >>> 1;
    assign w_s   = {{(S_W-D_W){r1_d[D_W-1]}}, r1_d} + w_h;
    assign w_p2  = {{(RES_W-C_W){r2_c[C_W-1]}}, r2_c}
                 * {{(RES_W-S_W){r2_s[S_W-1]}}, r2_s};
    assign w_exp = {{(RES_W-A_W){r3_a[A_W-1]}}, r3_a}
                 + {{(RES_W-B_W-64){1'b0}}, r3_b, 64'h0}
                 + r3_p2;

    always_ff @(posedge clk) begin
        r1_p1  <= w_p1;
        r1_a   <= A;
        r1_b   <= B;
        r1_c   <= C;
        r1_d   <= D;
        r2_s   <= w_s;
        r2_a   <= r1_a;
        r2_b   <= r1_b;
        r2_c   <= r1_c;
        r3_p2  <= w_p2;
        r3_a   <= r2_a;
        r3_b   <= r2_b;
        r4_exp <= w_exp;
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_v <= '0;
        end else begin
            r_v <= {r_v[EXP_LAT-2:0], in_valid && w_run};
        end
    end

    wide_mult_exp_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (start),
        .i_push  (w_push_req),
        .i_pop   (w_pop_req),
        .i_data  (r4_exp),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_pop_req  = w_run && res_valid;
        w_push_req = w_run && r_v[EXP_LAT-1];
        w_uf       = w_pop_req && w_empty;
        w_of       = w_push_req && w_full && !w_pop_req;
        w_pop      = w_pop_req && !w_empty;
        w_mis      = w_pop && (w_head != res);
        w_chk_nxt  = r_chk;
        if (w_pop && r_chk != 16'hFFFF) w_chk_nxt = r_chk + 16'd1;
        w_mis_nxt  = r_mis;
        if (w_mis && r_mis != 16'hFFFF) w_mis_nxt = r_mis + 16'd1;
        w_fbi_nxt  = r_fbi;
        if (w_mis && r_mis == 16'd0) w_fbi_nxt = r_chk;
        w_active   = !w_empty || (|r_v);
        w_to_hit   = 1'b0;
        w_to_nxt   = r_to;
        if (res_valid) begin
            w_to_nxt = '0;
        end else if (w_active) begin
            w_to_hit = (r_to == TO_W'(TIMEOUT - 1));
            if (r_to != TO_W'(TIMEOUT)) w_to_nxt = r_to + 1'b1;
        end
        w_any_err  = r_uf || w_uf || r_of || w_of || r_to_err || w_to_hit;
        w_finish   = (w_chk_nxt == 16'(NUM_VECTORS)) || w_any_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_chk    <= '0;
            r_mis    <= '0;
            r_fbi    <= 16'hFFFF;
            r_uf     <= 1'b0;
            r_of     <= 1'b0;
            r_to_err <= 1'b0;
            r_to     <= '0;
        end else if (start) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_chk    <= '0;
            r_mis    <= '0;
            r_fbi    <= 16'hFFFF;
            r_uf     <= 1'b0;
            r_of     <= 1'b0;
            r_to_err <= 1'b0;
            r_to     <= '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    r_chk    <= w_chk_nxt;
                    r_mis    <= w_mis_nxt;
                    r_fbi    <= w_fbi_nxt;
                    r_uf     <= r_uf || w_uf;
                    r_of     <= r_of || w_of;
                    r_to_err <= r_to_err || w_to_hit;
                    r_to     <= w_to_nxt;
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mis_nxt == 16'd0) && !w_any_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign checked_count  = r_chk;
    assign mismatch_count = r_mis;
    assign first_bad_idx  = r_fbi;
    assign err_underflow  = r_uf;
    assign err_overflow   = r_of;
    assign err_timeout    = r_to_err;

endmodule

// File: tb/tb_wide_mult_checker.sv
// Randomised scoreboard bench for wide_mult_checker with a latency-7
// behavioural model of the checked DUT feeding the result stream.
module tb_wide_mult_checker;

    localparam int NV  = 47;
    localparam int LAT = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [127:0] A;
    logic [63:0]  B;
    logic [63:0]  C;
    logic [127:0] D;
    logic [127:0] E;
    logic         res_valid;
    logic [255:0] res;
    logic         busy;
    logic         done;
    logic         pass;
    logic [15:0]  checked_count;
    logic [15:0]  mismatch_count;
    logic [15:0]  first_bad_idx;
    logic         err_underflow;
    logic         err_overflow;
    logic         err_timeout;

    wide_mult_checker #(
        .NUM_VECTORS (NV),
        .FIFO_DEPTH  (16),
        .TIMEOUT     (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_valid       (in_valid),
        .A              (A),
        .B              (B),
        .C              (C),
        .D              (D),
        .E              (E),
        .res_valid      (res_valid),
        .res            (res),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .checked_count  (checked_count),
        .mismatch_count (mismatch_count),
        .first_bad_idx  (first_bad_idx),
        .err_underflow  (err_underflow),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [255:0] val;
    } dres_t;

    typedef struct {
        logic [15:0] chk;
        logic [15:0] mis;
        logic [15:0] fbi;
        logic        uf;
        logic        dn;
        logic        ps;
    } out_t;

    dres_t        dut_q[$];
    logic [255:0] ref_q[$];
    out_t         sb_q[$];

    int          checks = 0;
    int          fails  = 0;
    logic [15:0] m_chk;
    logic [15:0] m_mis;
    logic [15:0] m_fbi;
    logic        m_uf;
    int          last_rv = 0;
    logic        rv_q = 1'b0;
    out_t        mon_o;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: A + B*2^64 + C*(D + floor(C*E/2)) in plain signed arithmetic
    function automatic logic [255:0] model(input logic [127:0] a,
        input logic [63:0] b, input logic [63:0] c,
        input logic [127:0] d, input logic [127:0] e);
        logic signed [255:0] sa, sc, sd, se, half;
        sa   = $signed(a);
        sc   = $signed(c);
        sd   = $signed(d);
        se   = $signed(e);
        half = (sc * se) >>> 1;
        return sa + sc * (sd + half) + {128'b0, b, 64'b0};
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_chk = 16'd0;
        m_mis = 16'd0;
        m_fbi = 16'hFFFF;
        m_uf  = 1'b0;
        ref_q.delete();
        dut_q.delete();
        sb_q.delete();
    endtask

    task automatic model_result(input logic [255:0] r);
        out_t         o;
        logic [255:0] x;
        if (ref_q.size() == 0) begin
            m_uf = 1'b1;
        end else begin
            x = ref_q.pop_front();
            if (x !== r) begin
                if (m_mis == 16'd0) m_fbi = m_chk;
                m_mis++;
            end
            m_chk++;
        end
        o.chk = m_chk;
        o.mis = m_mis;
        o.fbi = m_fbi;
        o.uf  = m_uf;
        o.dn  = (m_chk == 16'(NV)) || m_uf;
        o.ps  = o.dn && (m_mis == 16'd0) && !m_uf;
        sb_q.push_back(o);
    endtask

    // Model of the checked DUT: returns each queued result at its due cycle
    always @(posedge clk) begin
        dres_t dr;
        #1;
        if (dut_q.size() > 0 && dut_q[0].due <= cyc) begin
            dr        = dut_q.pop_front();
            res_valid = 1'b1;
            res       = dr.val;
            model_result(dr.val);
        end else begin
            res_valid = 1'b0;
        end
    end

    always @(posedge clk) rv_q <= res_valid;

    always @(negedge clk) begin
        if (res_valid) last_rv = cyc;
        if (rv_q) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_empty actual=result required=none");
            end else begin
                mon_o = sb_q.pop_front();
                check("checked_count", 256'(checked_count), 256'(mon_o.chk));
                check("mismatch_count", 256'(mismatch_count), 256'(mon_o.mis));
                check("first_bad_idx", 256'(first_bad_idx), 256'(mon_o.fbi));
                check("err_underflow", 256'(err_underflow), 256'(mon_o.uf));
                check("done", 256'(done), 256'(mon_o.dn));
                check("pass", 256'(pass), 256'(mon_o.ps));
            end
        end
    end

    task automatic send(input logic [127:0] a, input logic [63:0] b,
        input logic [63:0] c, input logic [127:0] d, input logic [127:0] e,
        input bit use_ovr, input logic [255:0] ovr,
        input bit flip, input bit drop);
        logic [255:0] x;
        dres_t        dr;
        @(posedge clk);
        #1;
        A        = a;
        B        = b;
        C        = c;
        D        = d;
        E        = e;
        in_valid = 1'b1;
        x = use_ovr ? ovr : model(a, b, c, d, e);
        ref_q.push_back(x);
        if (flip) x[0] = ~x[0];
        dr.due = cyc + LAT;
        dr.val = x;
        if (!drop) dut_q.push_back(dr);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start    = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((dut_q.size() != 0 || sb_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            fails++;
            $display("FAIL drain actual=stalled required=empty");
        end
        @(negedge clk);
    endtask

    task automatic rand_run(input int n, input int bad);
        for (int i = 0; i < n; i++)
            send(r128(), 64'(r128()), 64'(r128()), r128(), r128(),
                 1'b0, '0, (i == bad), 1'b0);
        idle();
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        dres_t dr;
        int    n;
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        res_valid = 1'b0;
        A = '0; B = '0; C = '0; D = '0; E = '0;
        res = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_checked", 256'(checked_count), 256'd0);
        check("rst_mismatch", 256'(mismatch_count), 256'd0);
        check("rst_first_bad", 256'(first_bad_idx), 256'hFFFF);
        check("rst_status", 256'({busy, done, pass}), 256'd0);
        check("rst_errs", 256'({err_underflow, err_overflow, err_timeout}), 256'd0);

        do_start();
        send(128'd2, 64'd2, 64'd2, 128'd2, 128'd2,
             1'b1, 256'h2_0000_0000_0000_000A, 1'b0, 1'b0);
        send(128'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0, 128'd3,
             1'b1, 256'd2, 1'b0, 1'b0);
        idle();
        drain();
        check("dir_checked", 256'(checked_count), 256'd2);
        check("dir_mismatch", 256'(mismatch_count), 256'd0);
        check("dir_busy", 256'({busy, done}), 256'b10);

        do_start();
        rand_run(NV, -1);
        check("full_done", 256'({done, pass, busy}), 256'b110);
        check("full_checked", 256'(checked_count), 256'(NV));

        do_start();
        rand_run(NV, 5);
        check("bad_mismatch", 256'(mismatch_count), 256'd1);
        check("bad_first_idx", 256'(first_bad_idx), 256'd5);
        check("bad_pass", 256'({done, pass}), 256'b10);

        do_start();
        @(posedge clk);
        #1;
        dr.due = cyc + 1;
        dr.val = r128();
        dut_q.push_back(dr);
        drain();
        check("uf_flag", 256'(err_underflow), 256'd1);
        check("uf_state", 256'({done, pass, busy}), 256'b100);

        do_start();
        for (int i = 0; i < 3; i++)
            send(r128(), 64'(r128()), 64'(r128()), r128(), r128(),
                 1'b0, '0, 1'b0, (i == 2));
        idle();
        drain();
        n = 0;
        while (!err_timeout && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 256'(cyc - last_rv), 256'd65);
        check("to_state", 256'({done, pass, err_underflow, err_overflow}), 256'b1000);
        check("to_checked", 256'(checked_count), 256'd2);

        do_start();
        rand_run(10, -1);
        check("mid_checked", 256'(checked_count), 256'd10);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("mr_checked", 256'(checked_count), 256'd0);
        check("mr_first_bad", 256'(first_bad_idx), 256'hFFFF);
        check("mr_status", 256'({busy, done, pass}), 256'd0);
        check("mr_errs", 256'({err_underflow, err_overflow, err_timeout}), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
